phys_reg_free_list: RTL and testbench

- Circular FIFO of free physical register tags that supplies new_phys_rd to the rename table on each rename.
- Reclaims the superseded physical tag when an instruction commits.
- Keeps a committed head pointer so that a pipeline flush returns every speculatively allocated tag in one cycle.
- Sits between the decode/rename stage (allocate side) and the ROB commit stage (release side).

---
 rtl/phys_reg_free_list_if.sv | 44 ++++
 rtl/phys_reg_free_list.sv | 116 +++++++++++
 tb/tb_phys_reg_free_list.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/phys_reg_free_list_if.sv
// -----------------------------------------------------------------------------
// phys_reg_free_list_if
// Bundles the allocate / commit / release / flush signals of the physical
// register free list.
//   master : rename + ROB side (drives requests, observes list status)
//   slave  : the free list itself
// Signals:
//   alloc_req    rename consumes the head tag this cycle
//   alloc_valid  head tag is valid
//   alloc_phys   tag at head (new_phys_rd for the rename table)
//   commit_en    oldest outstanding allocation retires
//   release_en   push release_phys onto the tail
//   release_phys superseded mapping of the committing arch register
//   flush        squash every speculative allocation
//   free_count   entries between head and tail
//   empty/full   decoded from free_count
//   err          sticky protocol-violation flag
// -----------------------------------------------------------------------------
interface phys_reg_free_list_if #(
    parameter int PW = 6,
    parameter int CW = 5
);
    logic          alloc_req;
    logic          alloc_valid;
    logic [PW-1:0] alloc_phys;
    logic          commit_en;
    logic          release_en;
    logic [PW-1:0] release_phys;
    logic          flush;
    logic [CW-1:0] free_count;
    logic          empty;
    logic          full;
    logic          err;

    modport master (
        output alloc_req, commit_en, release_en, release_phys, flush,
        input  alloc_valid, alloc_phys, free_count, empty, full, err
    );

    modport slave (
        input  alloc_req, commit_en, release_en, release_phys, flush,
        output alloc_valid, alloc_phys, free_count, empty, full, err
    );
endinterface

// File: rtl/phys_reg_free_list.sv
// -----------------------------------------------------------------------------
// phys_reg_free_list
// Circular FIFO of free physical register tags.
//   - The head supplies new tags to rename (zero-cycle: the head tag is
//     visible combinationally and consumed on the edge).
//   - The tail receives superseded tags at commit.
//   - commit_head trails head and marks allocations that have retired; a
//     flush snaps head back to it, returning all speculative tags at once.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-low
//   fl     slave side of phys_reg_free_list_if (see interface header)
// Tags 0..ARCH_REGS-1 are architecturally mapped at reset, so the list
// starts full with ARCH_REGS..PHYS_REGS-1.
// -----------------------------------------------------------------------------
module phys_reg_free_list #(
    parameter int ARCH_REGS = 32,
    parameter int PHYS_REGS = 48
) (
    input  logic                 clk,
    input  logic                 reset,
    phys_reg_free_list_if.slave  fl
);
    localparam int FREE_REGS = PHYS_REGS - ARCH_REGS;
    localparam int PW        = $clog2(PHYS_REGS);
    localparam int CW        = $clog2(FREE_REGS + 1);
    localparam int IW        = (FREE_REGS > 1) ? $clog2(FREE_REGS) : 1;

    // Pointer increment modulo FREE_REGS (depth need not be a power of two).
    function automatic logic [IW-1:0] ptr_inc(input logic [IW-1:0] p);
        return (p == IW'(FREE_REGS - 1)) ? '0 : p + 1'b1;
    endfunction

    logic [FREE_REGS-1:0][PW-1:0] mem_q;
    logic [IW-1:0]                head_q,  head_d;
    logic [IW-1:0]                chead_q, chead_d;
    logic [IW-1:0]                tail_q,  tail_d;
    // cnt: head..tail (allocatable). ccnt: commit_head..tail (what the list
    // would hold after a flush). Kept explicitly because equal pointers are
    // ambiguous between full and empty.
    logic [CW-1:0]                cnt_q,   cnt_d;
    logic [CW-1:0]                ccnt_q,  ccnt_d;
    logic                         err_q,   err_d;

    logic          has_free;
    logic [CW-1:0] outstanding;
    logic          alloc_ok, alloc_bad;
    logic          com_ok,   com_bad;
    logic          rel_nz,   rel_room, rel_ok, rel_bad;

    always_comb begin
        has_free    = (cnt_q != '0);
        // Allocations handed out but not yet retired.
        outstanding = ccnt_q - cnt_q;

        alloc_ok  = fl.alloc_req && has_free  && !fl.flush;
        alloc_bad = fl.alloc_req && !has_free && !fl.flush;

        com_ok  = fl.commit_en && (outstanding != '0);
        com_bad = fl.commit_en && (outstanding == '0);

        // x0 never gets a real physical tag, so its "release" is dropped.
        // A same-cycle commit frees a slot before the release lands, which is
        // the normal retire pattern when the list holds every free tag.
        rel_nz   = fl.release_en && (fl.release_phys != '0);
        rel_room = (ccnt_q - CW'(com_ok)) != CW'(FREE_REGS);
        rel_ok   = rel_nz && rel_room;
        rel_bad  = rel_nz && !rel_room;
    end

    always_comb begin
        head_d  = alloc_ok ? ptr_inc(head_q)  : head_q;
        chead_d = com_ok   ? ptr_inc(chead_q) : chead_q;
        tail_d  = rel_ok   ? ptr_inc(tail_q)  : tail_q;
        cnt_d   = cnt_q  + CW'(rel_ok) - CW'(alloc_ok);
        ccnt_d  = ccnt_q + CW'(rel_ok) - CW'(com_ok);
        err_d   = err_q | alloc_bad | com_bad | rel_bad;

        // Flush lands on top of this cycle's commit/release results.
        if (fl.flush) begin
            head_d = chead_d;
            cnt_d  = ccnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < FREE_REGS; i++)
                mem_q[i] <= PW'(ARCH_REGS + i);
            head_q  <= '0;
            chead_q <= '0;
            tail_q  <= '0;
            cnt_q   <= CW'(FREE_REGS);
            ccnt_q  <= CW'(FREE_REGS);
            err_q   <= 1'b0;
        end else begin
            if (rel_ok)
                mem_q[tail_q] <= fl.release_phys;
            head_q  <= head_d;
            chead_q <= chead_d;
            tail_q  <= tail_d;
            cnt_q   <= cnt_d;
            ccnt_q  <= ccnt_d;
            err_q   <= err_d;
        end
    end

    // No release-to-alloc bypass: alloc_phys only ever reads registered state.
    assign fl.alloc_phys  = mem_q[head_q];
    assign fl.alloc_valid = (cnt_q != '0);
    assign fl.empty       = (cnt_q == '0);
    assign fl.full        = (cnt_q == CW'(FREE_REGS));
    assign fl.free_count  = cnt_q;
    assign fl.err         = err_q;

endmodule

// File: tb/tb_phys_reg_free_list.sv
module tb_phys_reg_free_list;
    localparam int PW = 6;
    localparam int CW = 5;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    phys_reg_free_list_if #(.PW(PW), .CW(CW)) fl ();

    phys_reg_free_list #(.ARCH_REGS(32), .PHYS_REGS(48)) dut (
        .clk   (clk),
        .reset (reset),
        .fl    (fl)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        fl.alloc_req    = 1'b0;
        fl.commit_en    = 1'b0;
        fl.release_en   = 1'b0;
        fl.release_phys = '0;
        fl.flush        = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        idle();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;

        // Reset state
        chk("rst_valid", 32'(fl.alloc_valid), 1);
        chk("rst_phys",  32'(fl.alloc_phys), 32);
        chk("rst_full",  32'(fl.full), 1);
        chk("rst_empty", 32'(fl.empty), 0);
        chk("rst_count", 32'(fl.free_count), 16);
        chk("rst_err",   32'(fl.err), 0);

        // 16 back-to-back allocations drain the list: 32..47
        for (int i = 0; i < 16; i++) begin
            chk("drain_phys", 32'(fl.alloc_phys), 32'(32 + i));
            fl.alloc_req = 1'b1;
            tick();
        end
        idle();
        chk("drain_valid", 32'(fl.alloc_valid), 0);
        chk("drain_empty", 32'(fl.empty), 1);
        chk("drain_count", 32'(fl.free_count), 0);
        chk("drain_full",  32'(fl.full), 0);
        chk("drain_err",   32'(fl.err), 0);

        // From empty: retire + release tag 5 with a rejected alloc alongside
        fl.alloc_req    = 1'b1;
        fl.commit_en    = 1'b1;
        fl.release_en   = 1'b1;
        fl.release_phys = 6'd5;
        tick();
        idle();
        chk("refill_valid", 32'(fl.alloc_valid), 1);
        chk("refill_phys",  32'(fl.alloc_phys), 5);
        chk("refill_count", 32'(fl.free_count), 1);
        chk("refill_err",   32'(fl.err), 1);

        // Mid-sequence reset discards everything, clears err
        do_reset();
        chk("rst2_phys",  32'(fl.alloc_phys), 32);
        chk("rst2_count", 32'(fl.free_count), 16);
        chk("rst2_err",   32'(fl.err), 0);

        // Release while committed count is full: suppressed, err set
        fl.release_en   = 1'b1;
        fl.release_phys = 6'd9;
        tick();
        idle();
        chk("ovf_phys",  32'(fl.alloc_phys), 32);
        chk("ovf_count", 32'(fl.free_count), 16);
        chk("ovf_err",   32'(fl.err), 1);

        // Alloc 4, commit 1, flush -> head back to 33, count 15
        do_reset();
        for (int i = 0; i < 4; i++) begin
            fl.alloc_req = 1'b1;
            tick();
        end
        idle();
        chk("alloc4_phys",  32'(fl.alloc_phys), 36);
        chk("alloc4_count", 32'(fl.free_count), 12);
        fl.commit_en = 1'b1;
        tick();
        idle();
        chk("commit1_count", 32'(fl.free_count), 12);
        fl.flush     = 1'b1;
        fl.alloc_req = 1'b1;
        tick();
        idle();
        chk("flush_phys",  32'(fl.alloc_phys), 33);
        chk("flush_count", 32'(fl.free_count), 15);
        chk("flush_err",   32'(fl.err), 0);

        // Release of x0 mapping is silently ignored
        fl.release_en   = 1'b1;
        fl.release_phys = 6'd0;
        tick();
        idle();
        chk("x0_count", 32'(fl.free_count), 15);
        chk("x0_err",   32'(fl.err), 0);

        // Alloc 3, then commit + release(7) + flush in one cycle
        do_reset();
        for (int i = 0; i < 3; i++) begin
            fl.alloc_req = 1'b1;
            tick();
        end
        idle();
        fl.commit_en    = 1'b1;
        fl.release_en   = 1'b1;
        fl.release_phys = 6'd7;
        fl.flush        = 1'b1;
        tick();
        idle();
        chk("cfr_count", 32'(fl.free_count), 16);
        chk("cfr_phys",  32'(fl.alloc_phys), 33);
        chk("cfr_full",  32'(fl.full), 1);
        chk("cfr_err",   32'(fl.err), 0);
        // 15 more allocs wrap head onto slot 0, which now holds 7
        for (int i = 0; i < 15; i++) begin
            fl.alloc_req = 1'b1;
            tick();
        end
        idle();
        chk("cfr_tail_phys",  32'(fl.alloc_phys), 7);
        chk("cfr_tail_count", 32'(fl.free_count), 1);

        // Wrap-around: drain, retire/release 1..16, reallocate 1..16
        do_reset();
        for (int i = 0; i < 16; i++) begin
            fl.alloc_req = 1'b1;
            tick();
        end
        idle();
        chk("wrap_empty", 32'(fl.empty), 1);
        for (int i = 0; i < 16; i++) begin
            fl.commit_en    = 1'b1;
            fl.release_en   = 1'b1;
            fl.release_phys = 6'(i + 1);
            tick();
        end
        idle();
        chk("wrap_count", 32'(fl.free_count), 16);
        chk("wrap_full",  32'(fl.full), 1);
        chk("wrap_err",   32'(fl.err), 0);
        for (int i = 0; i < 16; i++) begin
            chk("wrap_phys", 32'(fl.alloc_phys), 32'(i + 1));
            fl.alloc_req = 1'b1;
            tick();
            if (i == 0) begin
                chk("wrap_notfull", 32'(fl.full), 0);
            end
        end
        idle();
        chk("wrap_end_empty", 32'(fl.empty), 1);
        chk("wrap_end_count", 32'(fl.free_count), 0);
        chk("wrap_end_err",   32'(fl.err), 0);

        // Commit with nothing outstanding: ignored, err set
        do_reset();
        fl.commit_en = 1'b1;
        tick();
        idle();
        chk("bad_commit_err",   32'(fl.err), 1);
        chk("bad_commit_count", 32'(fl.free_count), 16);
        chk("bad_commit_phys",  32'(fl.alloc_phys), 32);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
